cv32e40p_mult_retry_ctrl: RTL and testbench
===========================================

# cv32e40p_mult_retry_ctrl

Fault-recovery sequencer between the EX-stage issue logic and `cv32e40p_mult_hardened`. It accepts one multiplier request at a time and holds its operands stable. It drives the TMR multiplier and watches its voter fault flag across every cycle of the operation. On a detected disagreement or a stalled completion it re-issues the operation, up to `MAX_RETRY` times. It then returns the result or an error, and maintains a fault counter plus a sticky permanent-fault flag for the fault-handling CSRs.

## Interface
- `MAX_RETRY`, 2: re-issues allowed after the first attempt; `0` means no retry.
- `TIMEOUT`, 16: max EXEC cycles per attempt without `mult_ready_i`; range 2..255.
- `CNT_W`, 8: fault counter width.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: controller idle, request accepted when both high.
- `req_i` in `mult_req_t`: packed multiplier inputs (operator, subword/signed, op a/b/c, imm, dot operands/signed, clpx fields).
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_result_o` out 32: voted result.
- `rsp_error_o` out 1: retries exhausted; result invalid.
- `mult_enable_o` out 1: multiplier enable.
- `mult_req_o` out `mult_req_t`: registered request to the multiplier.
- `mult_ex_ready_o` out 1: `ex_ready_i` of the multiplier.
- `mult_result_i` in 32: multiplier result.
- `mult_ready_i` in 1: multiplier ready.
- `mult_fault_i` in 1: multiplier voter fault flag.
- `clear_i` in 1: clears the counter and `perm_fault_o`.
- `fault_cnt_o` out `CNT_W`: saturating count of faulty attempts.
- `perm_fault_o` out 1: sticky, set when any request ends in error.

## Operation
- FSM states: IDLE, EXEC, FLUSH, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready_o=1`.
  - On handshake, register `req_i` into `mult_req_o`, clear `attempt`, `fault_seen` and `tmo_cnt`, go to EXEC.
- EXEC:
  - `mult_enable_o=1`; `mult_ex_ready_o = mult_ready_i`.
  - `fault_seen` is set by any cycle with `mult_fault_i`, including intermediate MULH cycles.
  - `tmo_cnt` increments each cycle.
  - Completion is `mult_ready_i`; the fault value for that cycle is OR'ed into the evaluation. A timeout (`tmo_cnt==TIMEOUT-1` and not `mult_ready_i`) counts as a faulty completion.
  - Clean completion: latch `mult_result_i`, set `rsp_error_o=0`, go to RESP.
  - Faulty completion with `attempt<MAX_RETRY`: increment the fault counter and `attempt`, go to FLUSH.
  - Faulty completion with `attempt==MAX_RETRY`: increment the fault counter, set `rsp_error_o=1` and `perm_fault_o=1`, latch `mult_result_i`, go to RESP.
- FLUSH:
  - One cycle with `mult_enable_o=0` and `mult_ex_ready_o=1`, which returns all three replica MULH FSMs to idle.
  - Clear `fault_seen` and `tmo_cnt`, go to EXEC.
- RESP:
  - `rsp_valid_o=1`; result and error stay stable.
  - On `rsp_ready_i`, go to IDLE. There is no IDLE bypass: the next request is accepted no earlier than the cycle after the response handshake.
- `mult_req_o` changes only on IDLE acceptance.
- Fault counter:
  - Saturates at `2^CNT_W-1`.
  - `clear_i` coincident with an increment: clear wins and the result is 0.
  - `clear_i` coincident with an error completion: `perm_fault_o` is set, because set wins over clear.
- Requests are still accepted while `perm_fault_o=1` (degraded operation).

## Timing
- Reset values:
  - `rsp_valid_o`, `rsp_error_o`, `mult_enable_o`, `mult_ex_ready_o`, `perm_fault_o`: 0.
  - `fault_cnt_o`, `rsp_result_o`, `mult_req_o`: 0.
  - `req_ready_o`: 1 from the first cycle after `rst` deasserts; it is held at 0 while `rst` is high.
- Single-cycle op, clean: accept at cycle T, EXEC at T+1, `rsp_valid_o` at T+2.
- An N-cycle op (MULH) adds N-1 cycles.
- Each retry adds 1 FLUSH cycle plus a full EXEC attempt.
- `rst` during any state abandons the operation: no response, state goes to IDLE, the counter is cleared.

## Configuration
- `CV32E40P_MULT_FAULT_CNT_EN` defined: `fault_cnt_o` is the saturating counter described above.
- Undefined: the counter register is removed and `fault_cnt_o` is tied to 0.
- In both cases, retry, timeout and `perm_fault_o` behaviour is unchanged.

## Structure
- In `cv32e40p_pkg`:
  - `mult_req_t`, a packed struct of all multiplier inputs.
  - The `mult_retry_state_e` enum.
- The timeout counter is a natural sub-module, `cv32e40p_mult_watchdog`, with ports for start, clear, limit and expired. The FSM stays in the top module.
- The controller does not instantiate `cv32e40p_mult_hardened`; the EX stage wires the two together.

## Test plan
- Clean MUL, `op_a=7`, `op_b=6`, single-cycle ready → `rsp_valid_o` at T+2 with result 42; `rsp_error_o=0`; counter 0.
- `mult_fault_i` pulsed in the first EXEC of a MUL, `MAX_RETRY=2` → one FLUSH cycle, re-EXEC, result 42 at T+4; counter 1; `perm_fault_o=0`.
- Fault on all attempts → 3 EXEC and 2 FLUSH cycles, then `rsp_error_o=1`; `perm_fault_o=1`; counter 3.
- MULH with fault only in an intermediate (non-ready) cycle → that attempt is treated as faulty and retried.
- `mult_ready_i` held low → timeout after 16 EXEC cycles counts as a fault; with retries exhausted, `rsp_error_o=1`.
- Counter at 255 with `CNT_W=8` plus one more fault → stays 255. `clear_i` together with a fault → counter 0. `rst` mid-EXEC → no `rsp_valid_o`; `req_ready_o=1` one cycle after reset.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the multiplier retry controller: the packed multiplier
// request bundle and the retry sequencer state encoding.
package cv32e40p_pkg;

   typedef enum logic [2:0] {
      MUL_MAC32 = 3'b000,
      MUL_MSU32 = 3'b001,
      MUL_I     = 3'b010,
      MUL_IR    = 3'b011,
      MUL_DOT8  = 3'b100,
      MUL_DOT16 = 3'b101,
      MUL_H     = 3'b110
   } mult_operator_e;

   typedef struct packed {
      mult_operator_e mul_op;
      logic           short_subword;
      logic [1:0]     short_signed;
      logic [31:0]    op_a;
      logic [31:0]    op_b;
      logic [31:0]    op_c;
      logic [4:0]     imm;
      logic [1:0]     dot_signed;
      logic [31:0]    dot_op_a;
      logic [31:0]    dot_op_b;
      logic [31:0]    dot_op_c;
      logic           is_clpx;
      logic [1:0]     clpx_shift;
      logic           clpx_img;
   } mult_req_t;

   typedef enum logic [1:0] {
      RS_IDLE  = 2'd0,
      RS_EXEC  = 2'd1,
      RS_FLUSH = 2'd2,
      RS_RESP  = 2'd3
   } mult_retry_state_e;

endpackage

// File: rtl/cv32e40p_mult_watchdog.sv
// Per-attempt cycle counter: flags expiry on the limit-th cycle of counting,
// combinationally, so the controller can act in that same cycle.
module cv32e40p_mult_watchdog #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic         i_clear,
   input  logic [W-1:0] i_limit,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_start && (r_cnt == (i_limit - 1'b1));

endmodule

// File: rtl/cv32e40p_mult_retry_ctrl.sv
// Retry sequencer around the TMR multiplier: re-issues on voter fault or timeout.
// Optional saturating fault counter enabled by CV32E40P_MULT_FAULT_CNT_EN.
module cv32e40p_mult_retry_ctrl
   import cv32e40p_pkg::*;
#(
   parameter int MAX_RETRY = 2,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  mult_req_t        req_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_error_o,
   output logic             mult_enable_o,
   output mult_req_t        mult_req_o,
   output logic             mult_ex_ready_o,
   input  logic [31:0]      mult_result_i,
   input  logic             mult_ready_i,
   input  logic             mult_fault_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] fault_cnt_o,
   output logic             perm_fault_o
);

   localparam int                ATT_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [ATT_W-1:0]  LAST_ATT = ATT_W'(MAX_RETRY);
   localparam logic [7:0]        TMO_LIM  = 8'(TIMEOUT);

   mult_retry_state_e r_state;
   logic [ATT_W-1:0]  r_attempt;
   logic              r_fault_seen;
   mult_req_t         r_req;
   logic [31:0]       r_result;
   logic              r_error;
   logic              r_perm;

   logic w_exec;
   logic w_expired;
   logic w_done;
   logic w_faulty;
   logic w_fault_inc;
   logic w_err_done;

   assign w_exec = (r_state == RS_EXEC);

   cv32e40p_mult_watchdog #(.W(8)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_exec),
      .i_clear   (!w_exec),
      .i_limit   (TMO_LIM),
      .o_expired (w_expired)
   );

   // A timeout completes the attempt without ready, which by itself marks it faulty.
   assign w_done      = mult_ready_i | w_expired;
   assign w_faulty    = r_fault_seen | mult_fault_i | ~mult_ready_i;
   assign w_fault_inc = w_exec & w_done & w_faulty;
   assign w_err_done  = w_fault_inc & (r_attempt == LAST_ATT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RS_IDLE;
         r_attempt    <= '0;
         r_fault_seen <= 1'b0;
         r_req        <= '0;
         r_result     <= '0;
         r_error      <= 1'b0;
      end else begin
         case (r_state)
            RS_IDLE: begin
               if (req_valid_i) begin
                  r_req        <= req_i;
                  r_attempt    <= '0;
                  r_fault_seen <= 1'b0;
                  r_state      <= RS_EXEC;
               end
            end
            RS_EXEC: begin
               if (mult_fault_i) begin
                  r_fault_seen <= 1'b1;
               end
               if (w_done) begin
                  if (!w_faulty) begin
                     r_result <= mult_result_i;
                     r_error  <= 1'b0;
                     r_state  <= RS_RESP;
                  end else if (r_attempt != LAST_ATT) begin
                     r_attempt <= r_attempt + 1'b1;
                     r_state   <= RS_FLUSH;
                  end else begin
                     r_result <= mult_result_i;
                     r_error  <= 1'b1;
                     r_state  <= RS_RESP;
                  end
               end
            end
            RS_FLUSH: begin
               r_fault_seen <= 1'b0;
               r_state      <= RS_EXEC;
            end
            RS_RESP: begin
               if (rsp_ready_i) begin
                  r_state <= RS_IDLE;
               end
            end
            default: r_state <= RS_IDLE;
         endcase
      end
   end

   // An error completion in the same cycle as clear still leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perm <= 1'b0;
      end else if (w_err_done) begin
         r_perm <= 1'b1;
      end else if (clear_i) begin
         r_perm <= 1'b0;
      end
   end

`ifdef CV32E40P_MULT_FAULT_CNT_EN
   logic [CNT_W-1:0] r_fault_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         r_fault_cnt <= '0;
      end else if (w_fault_inc && (r_fault_cnt != {CNT_W{1'b1}})) begin
         r_fault_cnt <= r_fault_cnt + 1'b1;
      end
   end

   assign fault_cnt_o = r_fault_cnt;
`else
   assign fault_cnt_o = '0;
`endif

   assign req_ready_o     = (r_state == RS_IDLE) & ~rst;
   assign rsp_valid_o     = (r_state == RS_RESP);
   assign rsp_result_o    = r_result;
   assign rsp_error_o     = r_error;
   assign mult_enable_o   = w_exec;
   assign mult_req_o      = r_req;
   // FLUSH pulses ex_ready with enable low so every replica's MULH FSM returns to idle.
   assign mult_ex_ready_o = w_exec ? mult_ready_i : (r_state == RS_FLUSH);
   assign perm_fault_o    = r_perm;

endmodule

// File: tb/tb_cv32e40p_mult_retry_ctrl.sv
// Directed bench for the multiplier retry controller with a behavioural multiplier.
module tb_cv32e40p_mult_retry_ctrl;
   import cv32e40p_pkg::*;

`ifdef CV32E40P_MULT_FAULT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready_o;
   mult_req_t   req;
   logic        rsp_valid_o;
   logic        rsp_ready;
   logic [31:0] rsp_result_o;
   logic        rsp_error_o;
   logic        mult_enable_o;
   mult_req_t   mult_req_o;
   logic        mult_ex_ready_o;
   logic [31:0] mult_result;
   logic        mult_ready;
   logic        mult_fault;
   logic        clear;
   logic [7:0]  fault_cnt_o;
   logic        perm_fault_o;

   int checks = 0;
   int errors = 0;
   int m_cnt  = 0;

   cv32e40p_mult_retry_ctrl #(.MAX_RETRY(2), .TIMEOUT(16), .CNT_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready_o),
      .req_i           (req),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready),
      .rsp_result_o    (rsp_result_o),
      .rsp_error_o     (rsp_error_o),
      .mult_enable_o   (mult_enable_o),
      .mult_req_o      (mult_req_o),
      .mult_ex_ready_o (mult_ex_ready_o),
      .mult_result_i   (mult_result),
      .mult_ready_i    (mult_ready),
      .mult_fault_i    (mult_fault),
      .clear_i         (clear),
      .fault_cnt_o     (fault_cnt_o),
      .perm_fault_o    (perm_fault_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_cnt();
      return CNT_EN ? 8'(m_cnt) : 8'd0;
   endfunction

   function automatic void bump(input int n);
      m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
   endfunction

   // Issues one request from a negedge and plays the multiplier: ready after
   // lat EXEC cycles per attempt (never if hang), fault on EXEC cycle k if fmap[k].
   task automatic run_req(input logic [31:0] a, input logic [31:0] b, input int lat,
                          input bit hang, input logic [63:0] fmap,
                          output int rlat, output int n_exec, output int n_flush,
                          output logic [31:0] res, output logic err,
                          output logic rdy_in_resp, output logic perm_at_rsp);
      int  c;
      bit  done;
      rlat = -1; n_exec = 0; n_flush = 0; res = '0; err = 1'b0;
      rdy_in_resp = 1'b1; perm_at_rsp = 1'b0; c = 0; done = 1'b0;
      req = '0;
      req.mul_op = MUL_I;
      req.op_a = a;
      req.op_b = b;
      req_valid = 1'b1;
      for (int i = 0; i < 50 && !req_ready_o; i++) @(negedge clk);
      if (!req_ready_o) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      for (int cyc = 1; cyc < 200; cyc++) begin
         mult_ready  = 1'b0;
         mult_fault  = 1'b0;
         mult_result = 32'hDEAD_BEEF;
         if (rsp_valid_o) begin
            rlat = cyc; res = rsp_result_o; err = rsp_error_o;
            rdy_in_resp = req_ready_o; perm_at_rsp = perm_fault_o;
            done = 1'b1;
            break;
         end
         if (mult_enable_o) begin
            mult_ready = !hang && (c == lat - 1);
            mult_fault = fmap[n_exec];
            if (mult_ready) mult_result = a * b;
            n_exec++;
            c++;
         end else if (mult_ex_ready_o) begin
            n_flush++;
            c = 0;
         end
         @(negedge clk);
      end
      if (!done) return;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   int          rl, ne, nf;
   logic [31:0] rr;
   logic        re, rq, rp;

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req = '0; rsp_ready = 1'b0; mult_result = '0;
      mult_ready = 1'b0; mult_fault = 1'b0; clear = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
      checks++; if (rsp_error_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b want 0", rsp_error_o); end
      checks++; if (mult_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", mult_enable_o); end
      checks++; if (mult_ex_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ex_ready: got %b want 0", mult_ex_ready_o); end
      checks++; if (perm_fault_o !== 1'b0) begin errors++; $display("FAIL reset_perm: got %b want 0", perm_fault_o); end
      checks++; if (fault_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", fault_cnt_o); end
      checks++; if (rsp_result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", rsp_result_o); end
      checks++; if (mult_req_o !== mult_req_t'('0)) begin errors++; $display("FAIL reset_mult_req: got %h want 0", mult_req_o); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready_o); end
   endtask

   task automatic test_clean_mul();
      run_req(32'd7, 32'd6, 1, 1'b0, 64'd0, rl, ne, nf, rr, re, rq, rp);
      checks++; if (rl !== 2) begin errors++; $display("FAIL clean_latency: got %0d want 2", rl); end
      checks++; if (rr !== 32'd42) begin errors++; $display("FAIL clean_result: got %0d want 42", rr); end
      checks++; if (re !== 1'b0) begin errors++; $display("FAIL clean_error: got %b want 0", re); end
      checks++; if (nf !== 0) begin errors++; $display("FAIL clean_flush: got %0d want 0", nf); end
      checks++; if (rq !== 1'b0) begin errors++; $display("FAIL clean_no_bypass: req_ready got %b want 0 in RESP", rq); end
      checks++; if (mult_req_o.op_a !== 32'd7 || mult_req_o.op_b !== 32'd6) begin errors++; $display("FAIL clean_mult_req: got %0d/%0d want 7/6", mult_req_o.op_a, mult_req_o.op_b); end
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL clean_cnt: got %0d want %0d", fault_cnt_o, exp_cnt()); end
   endtask

   task automatic test_retry_once();
      run_req(32'd7, 32'd6, 1, 1'b0, 64'd1, rl, ne, nf, rr, re, rq, rp);
      bump(1);
      checks++; if (rl !== 4) begin errors++; $display("FAIL retry_latency: got %0d want 4", rl); end
      checks++; if (rr !== 32'd42) begin errors++; $display("FAIL retry_result: got %0d want 42", rr); end
      checks++; if (ne !== 2 || nf !== 1) begin errors++; $display("FAIL retry_cycles: got exec %0d flush %0d want 2/1", ne, nf); end
      checks++; if (re !== 1'b0 || perm_fault_o !== 1'b0) begin errors++; $display("FAIL retry_error: got err %b perm %b want 0/0", re, perm_fault_o); end
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL retry_cnt: got %0d want %0d", fault_cnt_o, exp_cnt()); end
   endtask

   task automatic test_all_fail();
      run_req(32'd7, 32'd6, 1, 1'b0, {64{1'b1}}, rl, ne, nf, rr, re, rq, rp);
      bump(3);
      checks++; if (rl !== 6) begin errors++; $display("FAIL allfail_latency: got %0d want 6", rl); end
      checks++; if (ne !== 3 || nf !== 2) begin errors++; $display("FAIL allfail_cycles: got exec %0d flush %0d want 3/2", ne, nf); end
      checks++; if (re !== 1'b1) begin errors++; $display("FAIL allfail_error: got %b want 1", re); end
      checks++; if (rp !== 1'b1 || perm_fault_o !== 1'b1) begin errors++; $display("FAIL allfail_perm: got %b/%b want 1", rp, perm_fault_o); end
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL allfail_cnt: got %0d want %0d", fault_cnt_o, exp_cnt()); end
   endtask

   task automatic test_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_cnt = 0;
      checks++; if (perm_fault_o !== 1'b0) begin errors++; $display("FAIL clear_perm: got %b want 0", perm_fault_o); end
      checks++; if (fault_cnt_o !== 8'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", fault_cnt_o); end
   endtask

   task automatic test_mulh_intermediate();
      run_req(32'h1234, 32'h10, 3, 1'b0, 64'b10, rl, ne, nf, rr, re, rq, rp);
      bump(1);
      checks++; if (rl !== 8) begin errors++; $display("FAIL mulh_latency: got %0d want 8", rl); end
      checks++; if (ne !== 6 || nf !== 1) begin errors++; $display("FAIL mulh_cycles: got exec %0d flush %0d want 6/1", ne, nf); end
      checks++; if (rr !== 32'h12340 || re !== 1'b0) begin errors++; $display("FAIL mulh_result: got %h err %b want 00012340 err 0", rr, re); end
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL mulh_cnt: got %0d want %0d", fault_cnt_o, exp_cnt()); end
   endtask

   task automatic test_timeout();
      run_req(32'd3, 32'd5, 1, 1'b1, 64'd0, rl, ne, nf, rr, re, rq, rp);
      bump(3);
      checks++; if (rl !== 51) begin errors++; $display("FAIL timeout_latency: got %0d want 51", rl); end
      checks++; if (ne !== 48 || nf !== 2) begin errors++; $display("FAIL timeout_cycles: got exec %0d flush %0d want 48/2", ne, nf); end
      checks++; if (re !== 1'b1 || rp !== 1'b1) begin errors++; $display("FAIL timeout_error: got err %b perm %b want 1/1", re, rp); end
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL timeout_cnt: got %0d want %0d", fault_cnt_o, exp_cnt()); end
   endtask

   task automatic test_back_to_back();
      run_req(32'd11, 32'd13, 1, 1'b0, 64'd0, rl, ne, nf, rr, re, rq, rp);
      checks++; if (rl !== 2 || rr !== 32'd143) begin errors++; $display("FAIL b2b_first: got lat %0d res %0d want 2/143", rl, rr); end
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_rsp: got %b want 1", req_ready_o); end
      run_req(32'hFFFF_FFFF, 32'd2, 2, 1'b0, 64'd0, rl, ne, nf, rr, re, rq, rp);
      checks++; if (rl !== 3 || rr !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_second: got lat %0d res %h want 3/fffffffe", rl, rr); end
   endtask

   task automatic test_clear_priority();
      clear = 1'b1;
      run_req(32'd7, 32'd6, 1, 1'b0, 64'd1, rl, ne, nf, rr, re, rq, rp);
      checks++; if (fault_cnt_o !== 8'd0) begin errors++; $display("FAIL clrprio_cnt: got %0d want 0", fault_cnt_o); end
      checks++; if (rr !== 32'd42) begin errors++; $display("FAIL clrprio_result: got %0d want 42", rr); end
      run_req(32'd7, 32'd6, 1, 1'b0, {64{1'b1}}, rl, ne, nf, rr, re, rq, rp);
      checks++; if (rp !== 1'b1 || re !== 1'b1) begin errors++; $display("FAIL clrprio_perm_set: got perm %b err %b want 1/1", rp, re); end
      checks++; if (fault_cnt_o !== 8'd0) begin errors++; $display("FAIL clrprio_cnt2: got %0d want 0", fault_cnt_o); end
      clear = 1'b0;
      m_cnt = 0;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 85; k++) begin
         run_req(32'd1, 32'd1, 1, 1'b0, {64{1'b1}}, rl, ne, nf, rr, re, rq, rp);
         bump(3);
      end
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL sat_reach: got %0d want %0d", fault_cnt_o, exp_cnt()); end
      run_req(32'd1, 32'd1, 1, 1'b0, {64{1'b1}}, rl, ne, nf, rr, re, rq, rp);
      bump(3);
      checks++; if (fault_cnt_o !== exp_cnt()) begin errors++; $display("FAIL sat_hold: got %0d want %0d", fault_cnt_o, exp_cnt()); end
      checks++; if (rl !== 6 || re !== 1'b1) begin errors++; $display("FAIL sat_degraded: got lat %0d err %b want 6/1", rl, re); end
   endtask

   task automatic test_reset_mid_exec();
      bit saw_rsp;
      saw_rsp = 1'b0;
      req = '0;
      req.op_a = 32'd9;
      req_valid = 1'b1;
      mult_ready = 1'b0; mult_fault = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mult_enable_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_exec: got %b want 1", mult_enable_o); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b want 0", req_ready_o); end
      checks++; if (mult_enable_o !== 1'b0 || fault_cnt_o !== 8'd0 || perm_fault_o !== 1'b0) begin errors++; $display("FAIL rstmid_state: got en %b cnt %0d perm %b want 0/0/0", mult_enable_o, fault_cnt_o, perm_fault_o); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", req_ready_o); end
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid_o) saw_rsp = 1'b1;
         @(negedge clk);
      end
      checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp: got rsp_valid %b want 0", saw_rsp); end
   endtask

   initial begin
      test_reset();
      test_clean_mul();
      test_retry_once();
      test_all_fail();
      test_clear();
      test_mulh_intermediate();
      test_timeout();
      test_back_to_back();
      test_clear_priority();
      test_saturation();
      test_reset_mid_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
      $fatal(1, "bench did not terminate");
   end

endmodule
